// File: rtl/winner_finder_pkg.sv
// Shared constants and state encoding for the vote winner finder.
package winner_finder_pkg;

   localparam int NUM_CAND = 6;
   localparam int VOTE_W   = 8;
   localparam int TOTAL_W  = VOTE_W + 3;
   localparam int IDX_W    = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SCAN    = 2'd2,
      DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/winner_finder.sv
// Winner finder: snapshots six live vote counts, scans them one per cycle
// and publishes the highest count, its candidate index, a tie flag and the
// sum of all counts. Results hold until the next completed scan, an abort
// (mode dropping to voting) or reset.
module winner_finder #(
   parameter int NUM_CAND = winner_finder_pkg::NUM_CAND,
   parameter int VOTE_W   = winner_finder_pkg::VOTE_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mode,
   input  logic              start,
   input  logic [VOTE_W-1:0] candidate1_votes,
   input  logic [VOTE_W-1:0] candidate2_votes,
   input  logic [VOTE_W-1:0] candidate3_votes,
   input  logic [VOTE_W-1:0] candidate4_votes,
   input  logic [VOTE_W-1:0] candidate5_votes,
   input  logic [VOTE_W-1:0] candidate6_votes,
   output logic              busy,
   output logic              done,
   output logic [2:0]        winner,
   output logic [VOTE_W-1:0] winner_votes,
   output logic              tie,
   output logic [VOTE_W+2:0] total_votes
);

   import winner_finder_pkg::*;

   localparam int SUM_W = VOTE_W + 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND);

   state_t             state;
   logic [VOTE_W-1:0]  shadow [6];
   logic [IDX_W-1:0]   scan_idx;
   logic [VOTE_W-1:0]  run_max;
   logic [IDX_W-1:0]   run_win;
   logic               run_tie;
   logic [SUM_W-1:0]   run_sum;

   logic [VOTE_W-1:0]  cur_votes;
   logic [VOTE_W-1:0]  nxt_max;
   logic [IDX_W-1:0]   nxt_win;
   logic               nxt_tie;
   logic [SUM_W-1:0]   nxt_sum;

   // Select the snapshot count for the candidate under scan and fold it
   // into the running max / winner / tie / sum.
   always_comb begin
      cur_votes = '0;
      unique case (scan_idx)
         3'd1:    cur_votes = shadow[0];
         3'd2:    cur_votes = shadow[1];
         3'd3:    cur_votes = shadow[2];
         3'd4:    cur_votes = shadow[3];
         3'd5:    cur_votes = shadow[4];
         3'd6:    cur_votes = shadow[5];
         default: cur_votes = '0;
      endcase

      nxt_max = run_max;
      nxt_win = run_win;
      nxt_tie = run_tie;
      nxt_sum = run_sum + SUM_W'(cur_votes);
      if (cur_votes > run_max) begin
         nxt_max = cur_votes;
         nxt_win = scan_idx;
         nxt_tie = 1'b0;
      end else if ((cur_votes == run_max) && (run_max != '0)) begin
         // equal nonzero count: flag the tie, lower index stays winner
         nxt_tie = 1'b1;
      end
   end

   // Control FSM with the registered compare/accumulate stage and outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         for (int i = 0; i < 6; i++) shadow[i] <= '0;
         scan_idx     <= '0;
         run_max      <= '0;
         run_win      <= '0;
         run_tie      <= 1'b0;
         run_sum      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         winner       <= '0;
         winner_votes <= '0;
         tie          <= 1'b0;
         total_votes  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start && mode) begin
                  state <= CAPTURE;
                  busy  <= 1'b1;
               end
            end

            CAPTURE, SCAN: begin
               if (!mode) begin
                  // leaving the result phase mid-scan discards everything
                  state        <= IDLE;
                  busy         <= 1'b0;
                  done         <= 1'b0;
                  winner       <= '0;
                  winner_votes <= '0;
                  tie          <= 1'b0;
                  total_votes  <= '0;
               end else if (state == CAPTURE) begin
                  shadow[0] <= candidate1_votes;
                  shadow[1] <= candidate2_votes;
                  shadow[2] <= candidate3_votes;
                  shadow[3] <= candidate4_votes;
                  shadow[4] <= candidate5_votes;
                  shadow[5] <= candidate6_votes;
                  run_max   <= '0;
                  run_win   <= '0;
                  run_tie   <= 1'b0;
                  run_sum   <= '0;
                  scan_idx  <= 3'd1;
                  state     <= SCAN;
               end else begin
                  run_max <= nxt_max;
                  run_win <= nxt_win;
                  run_tie <= nxt_tie;
                  run_sum <= nxt_sum;
                  if (scan_idx == LAST_IDX) begin
                     state        <= DONE;
                     busy         <= 1'b0;
                     done         <= 1'b1;
                     winner       <= nxt_win;
                     winner_votes <= nxt_max;
                     tie          <= nxt_tie;
                     total_votes  <= nxt_sum;
                  end else begin
                     scan_idx <= scan_idx + 3'd1;
                  end
               end
            end

            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_winner_finder.sv
// Directed bench for winner_finder with hand-computed expectations.
module tb_winner_finder;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        mode  = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  c1 = '0, c2 = '0, c3 = '0, c4 = '0, c5 = '0, c6 = '0;
   logic        busy, done, tie;
   logic [2:0]  winner;
   logic [7:0]  winner_votes;
   logic [10:0] total_votes;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;
   int n;
   int d0;

   winner_finder dut (
      .clock            (clock),
      .reset            (reset),
      .mode             (mode),
      .start            (start),
      .candidate1_votes (c1),
      .candidate2_votes (c2),
      .candidate3_votes (c3),
      .candidate4_votes (c4),
      .candidate5_votes (c5),
      .candidate6_votes (c6),
      .busy             (busy),
      .done             (done),
      .winner           (winner),
      .winner_votes     (winner_votes),
      .tie              (tie),
      .total_votes      (total_votes)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (done) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_counts(input logic [7:0] a, b, c, d, e, f);
      c1 = a; c2 = b; c3 = c; c4 = d; c5 = e; c6 = f;
   endtask

   // One-cycle start pulse with mode=1; returns #1 after edge E0.
   task automatic launch();
      @(posedge clock); #1;
      mode = 1'b1;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   // Counts edges until done is seen (-1 if it never comes within the bound).
   task automatic wait_done(output int cycles);
      cycles = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clock); #1;
         if (done) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic check_result(input string tag, input int w, input int v,
                               input int t, input int tot);
      chk({tag, "_winner"}, winner, w);
      chk({tag, "_votes"},  winner_votes, v);
      chk({tag, "_tie"},    tie, t);
      chk({tag, "_total"},  total_votes, tot);
   endtask

   task automatic full_scan(input string tag, input int w, input int v,
                            input int t, input int tot);
      launch();
      chk({tag, "_busy"}, busy, 1);
      wait_done(n);
      chk({tag, "_latency"}, n, 7);
      chk({tag, "_busy_at_done"}, busy, 0);
      check_result(tag, w, v, t, tot);
      @(posedge clock); #1;
      chk({tag, "_done_pulse"}, done, 0);
      check_result({tag, "_hold"}, w, v, t, tot);
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      check_result("rst", 0, 0, 0, 0);
      @(posedge clock); #1;
      reset = 1'b1;

      // start while in voting phase is ignored
      d0 = done_cnt;
      mode = 1'b0;
      start = 1'b1;
      set_counts(8'd3, 8'd9, 8'd4, 8'd0, 8'd2, 8'd1);
      repeat (5) @(posedge clock);
      #1;
      chk("mode0_busy", busy, 0);
      start = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      chk("mode0_no_done", done_cnt - d0, 0);
      check_result("mode0", 0, 0, 0, 0);

      // basic winner
      full_scan("basic", 2, 9, 0, 19);

      // three-way tie at 7, lowest index wins
      set_counts(8'd5, 8'd7, 8'd7, 8'd2, 8'd0, 8'd7);
      full_scan("tie", 2, 7, 1, 28);

      // all zero: no winner, single done pulse
      set_counts(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
      d0 = done_cnt;
      full_scan("zero", 0, 0, 0, 0);
      chk("zero_one_done", done_cnt - d0, 1);

      // all saturated: full-width sum without wrap
      set_counts(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
      full_scan("max", 1, 255, 1, 1530);

      // abort by dropping mode at E0+3
      set_counts(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);
      d0 = done_cnt;
      launch();
      @(posedge clock);
      @(posedge clock); #1;
      mode = 1'b0;
      @(posedge clock); #1;
      chk("abort_busy", busy, 0);
      check_result("abort", 0, 0, 0, 0);
      mode = 1'b1;
      repeat (12) @(posedge clock);
      #1;
      chk("abort_no_done", done_cnt - d0, 0);
      full_scan("after_abort", 6, 6, 0, 21);

      // reset asserted at E0+4 clears outputs immediately, no done afterwards
      set_counts(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60);
      d0 = done_cnt;
      launch();
      repeat (4) @(posedge clock);
      reset = 1'b0;
      #1;
      chk("rst_mid_busy", busy, 0);
      check_result("rst_mid", 0, 0, 0, 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (12) @(posedge clock);
      #1;
      chk("rst_mid_no_done", done_cnt - d0, 0);
      check_result("rst_mid_after", 0, 0, 0, 0);

      // start while busy ignored; input changes mid-scan do not matter
      set_counts(8'd3, 8'd9, 8'd4, 8'd0, 8'd2, 8'd1);
      d0 = done_cnt;
      launch();
      @(posedge clock);
      @(posedge clock); #1;
      set_counts(8'd200, 8'd1, 8'd200, 8'd250, 8'd7, 8'd99);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(n);
      chk("busy_start_latency", n, 4);
      check_result("snapshot", 2, 9, 0, 19);
      repeat (12) @(posedge clock);
      #1;
      chk("busy_start_one_done", done_cnt - d0, 1);

      // start held high retriggers on the cycle after DONE
      set_counts(8'd0, 8'd0, 8'd8, 8'd0, 8'd8, 8'd3);
      @(posedge clock); #1;
      start = 1'b1;
      @(posedge clock); #1;
      wait_done(n);
      chk("hold_first_latency", n, 7);
      check_result("hold_first", 3, 8, 1, 19);
      set_counts(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd12);
      wait_done(n);
      start = 1'b0;
      chk("retrigger_gap", n, 9);
      check_result("retrigger", 6, 12, 0, 17);
      repeat (15) @(posedge clock);
      #1;
      chk("retrigger_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/winner_finder.md
WINNER_FINDER -- requirements
Module: winner_finder

Interface
REQ-001 The block SHALL have parameter NUM_CAND, default 6, meaning the number of candidate count inputs scanned.
REQ-002 The block SHALL have parameter VOTE_W, default 8, meaning the width of each candidate vote count.
REQ-003 Port clock  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  in  1  is the reset, which SHALL be asynchronous and active-low.
REQ-005 Port mode  in  1  SHALL select the phase: 0 = voting, 1 = result.
REQ-006 Port start  in  1  SHALL be the request to begin a winner scan, sampled as a level.
REQ-007 Ports candidate1_votes..candidate6_votes  in  VOTE_W each  SHALL carry the live counts from the vote-logging stage.
REQ-008 Port busy  out  1  SHALL be high while a scan is in progress.
REQ-009 Port done  out  1  SHALL be a one-cycle completion pulse.
REQ-010 Port winner  out  3  SHALL give the winning candidate index 1..6, or 0 for none.
REQ-011 Port winner_votes  out  VOTE_W  SHALL give the winning count.
REQ-012 Port tie  out  1  SHALL be high when two or more candidates share the maximum nonzero count.
REQ-013 Port total_votes  out  VOTE_W+3 (11)  SHALL give the sum of all six counts.

Function
REQ-014 The FSM SHALL have the states IDLE, CAPTURE, SCAN and DONE.
REQ-015 IDLE -> CAPTURE SHALL occur only when start=1 and mode=1 at the clock edge.
REQ-016 start asserted in any state other than IDLE SHALL be ignored; start asserted while mode=0 SHALL be ignored.
REQ-017 CAPTURE SHALL snapshot all six counts into shadow registers, clear the running max, index, tie and sum, and then go to SCAN.
REQ-018 SCAN SHALL process exactly one candidate per cycle in ascending index order 1..6, using a 3-bit index.
REQ-019 SCAN SHALL move to DONE after candidate 6.
REQ-020 Per-candidate compare rules:
- A count strictly greater than the running max SHALL become the new max and winner, and SHALL clear tie.
- A count equal to the running max, with the max nonzero, SHALL set tie and keep the lower index as winner.
REQ-021 If all counts are 0, the result SHALL be winner=0, winner_votes=0, tie=0.
REQ-022 total_votes SHALL accumulate the snapshot counts at full width with no overflow (maximum 1530).
REQ-023 In DONE, done SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE.
REQ-024 Latency: with start sampled at edge E0, done SHALL be high in the cycle following edge E0+7.
REQ-025 busy SHALL be high in the cycles following edges E0..E0+6 and low when done is high.
REQ-026 winner, winner_votes, tie and total_votes SHALL update only at DONE and SHALL hold until the next DONE, an abort or reset.
REQ-027 Abort: mode falling to 0 during CAPTURE or SCAN SHALL return the FSM to IDLE with no done pulse, and SHALL clear the result outputs to 0.
REQ-028 Changes to the count inputs during a scan SHALL NOT affect the result, because the scan uses the snapshot.
REQ-029 start held high continuously with mode=1 SHALL retrigger a new scan on the cycle after DONE.

Reset
REQ-030 reset low SHALL immediately force the state to IDLE and clear all shadow registers and the running max, index, tie and sum.
REQ-031 reset low SHALL immediately force busy=0, done=0, winner=0, winner_votes=0, tie=0 and total_votes=0.
REQ-032 Reset asserted mid-scan SHALL discard the scan, and no done pulse SHALL follow reset release.

Structure
REQ-033 The shared package SHALL hold NUM_CAND, VOTE_W, TOTAL_W=VOTE_W+3, the state encoding (IDLE=0, CAPTURE=1, SCAN=2, DONE=3) and the index-width constant.
REQ-034 The block SHALL be a single module with no sub-module; the compare/accumulate datapath is one registered stage inside the FSM.

Verification
REQ-035 Counts 3,9,4,0,2,1 with mode=1 and a start pulse -> done 8 cycles later, winner=2, winner_votes=9, tie=0, total_votes=19.
REQ-036 Counts 5,7,7,2,0,7 -> winner=2, winner_votes=7, tie=1, total_votes=28.
REQ-037 All counts 0 -> winner=0, winner_votes=0, tie=0, total_votes=0, and done pulses once.
REQ-038 All counts 255 -> winner=1, tie=1, total_votes=1530 with no wrap.
REQ-039 Counts 1,2,3,4,5,6 with mode dropped to 0 at edge E0+3 -> no done, all outputs 0; a later start gives winner=6, winner_votes=6.
REQ-040 reset asserted at edge E0+4, or start asserted while busy or with mode=0 -> outputs 0 and no extra done; changing the inputs mid-scan leaves the snapshot result unchanged.
